// File: rtl/stat_display.sv
// Display back-end for the pipeline statistics counters: debounced button picks a
// counter, shown as 8 hex digits on a multiplexed active-low 7-segment display.
module stat_display #(
  parameter int SCAN_DIV   = 100000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] total,
  input  logic [31:0] conditional,
  input  logic [31:0] unconditional,
  input  logic [31:0] conditional_success,
  input  logic [31:0] lu_times,
  input  logic        lock,
  input  logic        sel_btn,
  output logic [7:0]  seg,
  output logic [7:0]  an,
  output logic [2:0]  mode
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEB_CYCLES);

  logic          r_sync1, r_sync2;
  logic [1:0]    r_vld;
  logic          r_armed;
  logic          r_deb;
  logic [DW-1:0] r_deb_cnt;
  logic [2:0]    r_mode;
  logic          r_mode_chg;
  logic [SW-1:0] r_scan;
  logic [2:0]    r_idx;
  logic [31:0]   r_value;
  logic [7:0]    r_an, r_seg;

  logic          w_accept, w_adv, w_scan_wrap, w_frame_wrap, w_latch;
  logic [31:0]   w_sel_val;
  logic [3:0]    w_nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Counter select and event decode
  always_comb begin
    case (r_mode)
      3'd0:    w_sel_val = total;
      3'd1:    w_sel_val = conditional;
      3'd2:    w_sel_val = unconditional;
      3'd3:    w_sel_val = conditional_success;
      3'd4:    w_sel_val = lu_times;
      default: w_sel_val = 32'h0;
    endcase
    w_accept     = (r_sync2 != r_deb) && (r_deb_cnt == DW'(DEB_CYCLES - 1));
    w_adv        = w_accept & r_sync2 & r_armed;
    w_scan_wrap  = (r_scan == SW'(SCAN_DIV - 1));
    w_frame_wrap = w_scan_wrap & (r_idx == 3'd7);
    // a wrap coinciding with a mode change defers to the post-change latch
    w_latch      = (w_frame_wrap & ~w_adv) | r_mode_chg;
    w_nib        = r_value[{r_idx, 2'b00} +: 4];
  end

  // Button synchroniser, debouncer and mode selection
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_vld      <= 2'b00;
      r_armed    <= 1'b0;
      r_deb      <= 1'b0;
      r_deb_cnt  <= '0;
      r_mode     <= 3'd0;
      r_mode_chg <= 1'b0;
    end else begin
      r_sync1    <= sel_btn;
      r_sync2    <= r_sync1;
      r_vld      <= {r_vld[0], 1'b1};
      // a button held through reset must be seen released before it can advance mode
      r_armed    <= r_armed | (r_vld[1] & ~r_sync2);
      r_mode_chg <= w_adv;
      if (r_sync2 == r_deb) begin
        r_deb_cnt <= '0;
      end else if (w_accept) begin
        r_deb     <= r_sync2;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DW'(1);
      end
      if (w_adv) begin
        r_mode <= (r_mode == 3'd4) ? 3'd0 : r_mode + 3'd1;
      end else begin
        r_mode <= r_mode;
      end
    end
  end

  // Digit scan, value latch and registered display outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_scan  <= '0;
      r_idx   <= 3'd0;
      r_value <= 32'h0;
      r_an    <= 8'hFF;
      r_seg   <= 8'hFF;
    end else begin
      r_scan <= w_scan_wrap ? '0 : r_scan + SW'(1);
      if (w_scan_wrap) begin
        r_idx <= r_idx + 3'd1;
      end else begin
        r_idx <= r_idx;
      end
      if (w_latch) begin
        r_value <= w_sel_val;
      end else begin
        r_value <= r_value;
      end
      r_an  <= ~(8'b1 << r_idx);
      r_seg <= {~((r_idx == 3'd0) & lock), hex7(w_nib)};
    end
  end

  assign seg  = r_seg;
  assign an   = r_an;
  assign mode = r_mode;

endmodule

// File: tb/tb_stat_display.sv
// Directed self-checking bench for stat_display: hex/digit table plus sequences
// for reset, debounce, mode latch, anti-tearing and button-held-through-reset.
module tb_stat_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] total, conditional, unconditional, conditional_success, lu_times;
  logic        lock, sel_btn;
  logic [7:0]  seg, an;
  logic [2:0]  mode;

  int n_checks = 0;
  int n_fail   = 0;

  stat_display #(.SCAN_DIV(4), .DEB_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .total(total), .conditional(conditional),
    .unconditional(unconditional), .conditional_success(conditional_success),
    .lu_times(lu_times), .lock(lock), .sel_btn(sel_btn),
    .seg(seg), .an(an), .mode(mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tot;
    logic        lk;
    int          dig;
    logic [7:0]  exp_seg;
  } vec_t;

  vec_t vecs[16];

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_an(input logic [7:0] target);
    int k;
    k = 0;
    while (an !== target && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (an !== target) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_an timeout: an=%h, waiting for %h", an, target);
    end
  endtask

  // guarantees a full 7->0 wrap after the last input change
  task automatic wait_frame();
    wait_an(8'h7F);
    wait_an(8'hFE);
    wait_an(8'h7F);
    wait_an(8'hFE);
  endtask

  task automatic press();
    sel_btn = 1'b1;
    step(15);
    sel_btn = 1'b0;
    step(15);
  endtask

  function automatic logic [7:0] an_of(input int d);
    logic [7:0] one;
    one = 8'b1;
    return ~(one << d);
  endfunction

  initial begin
    logic [7:0] exp_s;
    int k;

    vecs[0]  = '{32'h1234ABCD, 1'b0, 0, 8'hA1};
    vecs[1]  = '{32'h1234ABCD, 1'b0, 1, 8'hC6};
    vecs[2]  = '{32'h1234ABCD, 1'b0, 2, 8'h83};
    vecs[3]  = '{32'h1234ABCD, 1'b0, 3, 8'h88};
    vecs[4]  = '{32'h1234ABCD, 1'b0, 4, 8'h99};
    vecs[5]  = '{32'h1234ABCD, 1'b0, 5, 8'hB0};
    vecs[6]  = '{32'h1234ABCD, 1'b0, 6, 8'hA4};
    vecs[7]  = '{32'h1234ABCD, 1'b0, 7, 8'hF9};
    vecs[8]  = '{32'h56789EF0, 1'b1, 0, 8'h40};
    vecs[9]  = '{32'h56789EF0, 1'b1, 1, 8'h8E};
    vecs[10] = '{32'h56789EF0, 1'b1, 2, 8'h86};
    vecs[11] = '{32'h56789EF0, 1'b1, 3, 8'h90};
    vecs[12] = '{32'h56789EF0, 1'b0, 4, 8'h80};
    vecs[13] = '{32'h56789EF0, 1'b0, 5, 8'hF8};
    vecs[14] = '{32'h56789EF0, 1'b0, 6, 8'h82};
    vecs[15] = '{32'h56789EF0, 1'b0, 0, 8'hC0};

    rst = 1'b0; total = 32'h0; conditional = 32'h0; unconditional = 32'h11111111;
    conditional_success = 32'h22222222; lu_times = 32'h33333333;
    lock = 1'b0; sel_btn = 1'b0;

    step(3);
    check("reset_an", {24'h0, an}, {24'h0, 8'hFF});
    check("reset_seg", {24'h0, seg}, {24'h0, 8'hFF});
    check("reset_mode", {29'h0, mode}, {29'h0, 3'd0});
    rst = 1'b1;
    step(1);
    check("first_an", {24'h0, an}, {24'h0, 8'hFE});

    for (int i = 0; i < 16; i++) begin
      total = vecs[i].tot;
      lock  = vecs[i].lk;
      wait_frame();
      wait_an(an_of(vecs[i].dig));
      check($sformatf("vec%0d_seg", i), {24'h0, seg}, {24'h0, vecs[i].exp_seg});
    end

    // anti-tearing: change mid-frame, only the next wrap picks it up
    lock = 1'b0; total = 32'h0;
    wait_frame();
    wait_an(8'hF7);
    total = 32'hFFFFFFFF;
    wait_an(8'hEF);
    check("tear_dig4_old", {24'h0, seg}, {24'h0, 8'hC0});
    wait_an(8'h7F);
    check("tear_dig7_old", {24'h0, seg}, {24'h0, 8'hC0});
    wait_an(8'hFE);
    check("tear_dig0_new", {24'h0, seg}, {24'h0, 8'h8E});
    wait_an(8'hDF);
    check("tear_dig5_new", {24'h0, seg}, {24'h0, 8'h8E});

    // debounce
    sel_btn = 1'b1; step(3); sel_btn = 1'b0; step(20);
    check("glitch_mode", {29'h0, mode}, {29'h0, 3'd0});
    sel_btn = 1'b1; step(20);
    check("held_mode", {29'h0, mode}, {29'h0, 3'd1});
    sel_btn = 1'b0; step(20);
    check("release_mode", {29'h0, mode}, {29'h0, 3'd1});
    press(); check("press_mode2", {29'h0, mode}, {29'h0, 3'd2});
    press(); check("press_mode3", {29'h0, mode}, {29'h0, 3'd3});
    press(); check("press_mode4", {29'h0, mode}, {29'h0, 3'd4});
    press(); check("press_wrap0", {29'h0, mode}, {29'h0, 3'd0});

    // mode change latches the new counter immediately
    total = 32'h1234ABCD; conditional = 32'h5;
    wait_frame();
    sel_btn = 1'b1;
    k = 0;
    while (mode == 3'd0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("latch_mode1", {29'h0, mode}, {29'h0, 3'd1});
    step(3);
    k = 8;
    for (int i = 0; i < 8; i++) if (an == an_of(i)) k = i;
    exp_s = (k == 0) ? 8'h92 : 8'hC0;
    check($sformatf("latch_fast_dig%0d", k), {24'h0, seg}, {24'h0, exp_s});
    wait_an(8'hFE);
    check("latch_dig0", {25'h0, seg[6:0]}, {25'h0, 7'b0010010});
    sel_btn = 1'b0; step(15);

    // reset mid-scan
    step(2);
    rst = 1'b0; step(1);
    check("midrst_an", {24'h0, an}, {24'h0, 8'hFF});
    check("midrst_seg", {24'h0, seg}, {24'h0, 8'hFF});
    check("midrst_mode", {29'h0, mode}, {29'h0, 3'd0});
    rst = 1'b1;

    // button held through reset release gives no advance
    sel_btn = 1'b1;
    rst = 1'b0; step(2); rst = 1'b1;
    step(20);
    check("held_thru_rst", {29'h0, mode}, {29'h0, 3'd0});
    sel_btn = 1'b0; step(15);
    sel_btn = 1'b1; step(15);
    check("after_rst_press", {29'h0, mode}, {29'h0, 3'd1});
    sel_btn = 1'b0; step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stat_display.md
Name: stat_display

Overview:
Display back-end for the pipeline statistics counter block. It consumes the five 32-bit statistics counters and the halt LOCK flag, and lets a debounced pushbutton pick one counter. The selected value is shown as 8 hex digits on the board's multiplexed active-low 7-segment display. Sits between the statistics unit and the FPGA top-level pins.

Parameters:
SCAN_DIV, 100000, clk cycles each digit stays lit (must be >=2)
DEB_CYCLES, 1000000, consecutive stable cycles before a button level change is accepted (must be >=2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low (0 = reset, sampled on posedge clk)
total  input  32  cycle count
conditional  input  32  conditional-branch count
unconditional  input  32  unconditional-jump count
conditional_success  input  32  taken conditional-branch count
lu_times  input  32  load-use stall count
lock  input  1  CPU halted, counters frozen
sel_btn  input  1  raw asynchronous pushbutton, active-high
seg  output  8  cathodes, active-low; seg[7]=dp, seg[6:0]=g,f,e,d,c,b,a
an  output  8  digit anodes, active-low; an[0]=rightmost digit
mode  output  3  selected counter index, drives LEDs

Behaviour:
- Reset (rst=0 at posedge): mode=0, digit index=0, scan count=0, latched value=0, debounce state cleared, an=8'hFF, seg=8'hFF. All state is synchronous; there is no async path.
- Button path:
  - 2-FF synchroniser on sel_btn.
  - A counter runs while the synchronised level differs from the debounced level. It clears whenever the two levels are equal.
  - When the counter reaches DEB_CYCLES-1, the debounced level takes the synchronised value and the counter clears.
  - A debounced 0->1 edge advances mode: 0,1,2,3,4,0,...
  - A held button gives exactly one advance. A release gives none.
- Mode map: 0=total, 1=conditional, 2=unconditional, 3=conditional_success, 4=lu_times. mode values 5-7 are unreachable; the mux yields 0 for them.
- Scan:
  - The scan counter counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the digit index increments mod 8.
- Value latch (anti-tearing):
  - The selected counter is latched into a 32-bit value register when the digit index wraps 7->0.
  - It is also latched in the cycle after a mode change, so a new selection shows within one cycle plus output latency.
  - Between these latch points the value register holds.
- Output stage, registered, 1-cycle latency from digit index/value register:
  - an = ~(8'b1 << idx).
  - seg[6:0] = hex decode of value[4*idx+3 : 4*idx].
  - seg[7] = 0 (dp lit) only when idx=0 and lock=1, otherwise 1.
- Hex decode (g..a, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Leading zeros are displayed; there is no blanking.
- Simultaneous events:
  - Mode change coinciding with a 7->0 wrap: latch once, from the new mode.
  - lock toggles take effect on dp at the next output register update.
- Reset mid-scan or mid-debounce: all state returns to reset values in the same edge. A button held through reset release yields no advance until released and pressed again.

Test Plan:
- Reset: rst=0 for 3 cycles -> an=8'hFF, seg=8'hFF, mode=0. First cycle after release, 1 cycle later -> an=8'hFE.
- Scan (SCAN_DIV=4, total=32'h1234ABCD, mode 0) -> after first frame, an steps FE,FD,FB,...,7F every 4 cycles. seg[6:0] on an=FE is 0100001 (d); on an=7F is 1111001 (1).
- Debounce (DEB_CYCLES=8): sel_btn pulses 3 cycles high then low -> mode stays 0. sel_btn held high 20 cycles -> mode=1 exactly once. Five clean presses from mode 0 -> mode returns to 0.
- Mode latch: mode 0 -> 1 with conditional=32'h5 -> within 3 cycles of the mode change, the digit-0 pattern is 0010010.
- Anti-tearing: change total from 32'h0 to 32'hFFFFFFFF while idx=3 -> digits 3..7 still show 0 until the next 7->0 wrap, then all digits show F (0001110).
- Halt dp: lock=1 -> seg[7]=0 only while an=FE, 1 on other digits. lock=0 -> seg[7]=1 on all digits.
